wheel_torque: RTL

WHEEL_TORQUE -- requirements
Module: wheel_torque

---
 rtl/wheel_torque.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wheel_torque.sv
// Wheel drive torque generator: snapshots node positions and the centre of mass,
// then emits one saturated tangential force pair per node per cycle.
module wheel_torque #(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int TORQUE        = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            input_valid,
    input  logic signed [2:0]               drive,
    input  logic signed [POSITION_SIZE-1:0] nodes [2][NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] com_x,
    input  logic signed [POSITION_SIZE-1:0] com_y,
    output logic signed [FORCE_SIZE-1:0]    torque_forces [2][NUM_NODES],
    output logic                            output_valid,
    output logic                            busy,
    output logic [1:0]                      dbg_state
);

    // Handshake: input_valid is a start request sampled only while idle (busy low);
    // output_valid is a single-cycle pulse and busy stays high through it.

    localparam int IW = $clog2(NUM_NODES + 1);
    localparam int SW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int PW = POSITION_SIZE + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NODES);
    localparam logic signed [31:0] F_MAX = (32'sd1 <<< (FORCE_SIZE - 1)) - 32'sd1;
    localparam logic signed [31:0] F_MIN = -(32'sd1 <<< (FORCE_SIZE - 1));

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic signed [2:0]               drive_q, drive_d;
    logic signed [POSITION_SIZE-1:0] com_x_q, com_x_d, com_y_q, com_y_d;
    logic signed [POSITION_SIZE-1:0] snap_q [2][NUM_NODES];
    logic signed [POSITION_SIZE-1:0] snap_d [2][NUM_NODES];
    logic                            wr_en_q, wr_en_d;
    logic [SW-1:0]                   wr_idx_q, wr_idx_d;
    logic signed [FORCE_SIZE-1:0]    fx_q, fx_d, fy_q, fy_d;
    logic signed [FORCE_SIZE-1:0]    forces_q [2][NUM_NODES];
    logic signed [FORCE_SIZE-1:0]    forces_d [2][NUM_NODES];

    logic [SW-1:0]         sel;
    logic signed [PW-1:0]  dx, dy;
    logic signed [31:0]    drive_ext, m, fx_raw, fy_raw;

    function automatic logic signed [FORCE_SIZE-1:0] sat(input logic signed [31:0] v);
        logic signed [31:0] r;
        if (v > F_MAX)      r = F_MAX;
        else if (v < F_MIN) r = F_MIN;
        else                r = v;
        return r[FORCE_SIZE-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drive_d  = drive_q;
        com_x_d  = com_x_q;
        com_y_d  = com_y_q;
        snap_d   = snap_q;
        wr_en_d  = 1'b0;
        wr_idx_d = wr_idx_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        forces_d = forces_q;

        sel       = idx_q[SW-1:0];
        dx        = {snap_q[0][sel][POSITION_SIZE-1], snap_q[0][sel]} -
                    {com_x_q[POSITION_SIZE-1], com_x_q};
        dy        = {snap_q[1][sel][POSITION_SIZE-1], snap_q[1][sel]} -
                    {com_y_q[POSITION_SIZE-1], com_y_q};
        drive_ext = {{29{drive_q[2]}}, drive_q};
        m         = TORQUE * drive_ext;
        // Tangential direction: fx follows -sgn(dy), fy follows +sgn(dx).
        if (dy == '0)     fx_raw = 32'sd0;
        else if (dy[PW-1]) fx_raw = m;
        else               fx_raw = -m;
        if (dx == '0)     fy_raw = 32'sd0;
        else if (dx[PW-1]) fy_raw = -m;
        else               fy_raw = m;

        // Second pipeline stage: commit the force pair computed last cycle.
        if (wr_en_q) begin
            forces_d[0][wr_idx_q] = fx_q;
            forces_d[1][wr_idx_q] = fy_q;
        end

        case (state_q)
            S_IDLE: begin
                if (input_valid) begin
                    snap_d  = nodes;
                    drive_d = drive;
                    com_x_d = com_x;
                    com_y_d = com_y;
                    idx_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    wr_en_d  = 1'b1;
                    wr_idx_d = sel;
                    fx_d     = sat(fx_raw);
                    fy_d     = sat(fy_raw);
                    idx_d    = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            drive_q  <= '0;
            com_x_q  <= '0;
            com_y_q  <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NUM_NODES; i++) begin
                    snap_q[k][i]   <= '0;
                    forces_q[k][i] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drive_q  <= drive_d;
            com_x_q  <= com_x_d;
            com_y_q  <= com_y_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            snap_q   <= snap_d;
            forces_q <= forces_d;
        end
    end

    assign torque_forces = forces_q;
    assign output_valid  = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule
